mem_arbiter: RTL

//  Shares one single-ported, fixed-latency unified memory between the fetch
//  (IF) and data (MEM) stages of the RISC-V pipeline. Grants one requester
//  at a time, sequences the access, returns read data with a one-cycle ready

---
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported, fixed-latency memory between fetch and data
// requesters. Data wins ties; a starvation counter forces a fetch grant after STARVE_MAX data grants.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2,
  parameter int STARVE_MAX  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ready,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_ready,
  output logic [DATA_W-1:0]   d_rdata,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall_if,
  output logic                stall_mem
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);
  localparam logic [STV_W-1:0] STV_LIM  = STV_W'(STARVE_MAX);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_IF, GNT_D} grant_t;

  state_t r_state, w_state_nxt;
  grant_t r_grant, w_grant_nxt;

  logic [CNT_W-1:0]  r_cnt;
  logic [STV_W-1:0]  r_starve;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [BE_W-1:0]   r_be;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic w_take_d;
  logic w_take_if;
  logic w_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= GNT_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_take_d    = 1'b0;
    w_take_if   = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        // A data request yields only when fetch has already lost STARVE_MAX times in a row.
        if (d_req && !(if_req && (r_starve == STV_LIM))) begin
          w_take_d    = 1'b1;
          w_grant_nxt = GNT_D;
          w_state_nxt = ST_ACCESS;
        end else if (if_req) begin
          w_take_if   = 1'b1;
          w_grant_nxt = GNT_IF;
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (r_cnt == '0) begin
          w_done      = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        w_grant_nxt = GNT_NONE;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_grant_nxt = GNT_NONE;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_starve   <= '0;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      if (w_take_d) begin
        r_addr  <= d_addr;
        r_we    <= d_we;
        r_be    <= d_be;
        r_wdata <= d_wdata;
        r_cnt   <= CNT_INIT;
      end else if (w_take_if) begin
        r_addr  <= if_addr;
        r_we    <= 1'b0;
        r_be    <= '1;
        r_cnt   <= CNT_INIT;
      end else if ((r_state == ST_ACCESS) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end

      if (w_done && !r_we) begin
        if (r_grant == GNT_IF) r_if_rdata <= mem_rdata;
        else                   r_d_rdata  <= mem_rdata;
      end

      if (w_take_if) begin
        r_starve <= '0;
      end else if (w_take_d && if_req) begin
        if (r_starve != STV_LIM) r_starve <= r_starve + 1'b1;
      end else if ((r_state == ST_IDLE) && !if_req) begin
        r_starve <= '0;
      end
    end
  end

  // Memory strobes come only from the latched request, so requester changes mid-access are invisible.
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_we    = (r_state == ST_ACCESS) && r_we;
  assign mem_be    = (r_state == ST_ACCESS) ? r_be : '0;

  assign if_ready  = (r_state == ST_RESP) && (r_grant == GNT_IF);
  assign d_ready   = (r_state == ST_RESP) && (r_grant == GNT_D);
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;

  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = d_req & ~d_ready;

endmodule
